// File: rtl/memory.sv
// rtl/memory.sv - single-port word-wide data memory for the load/store stage
// Synchronous write, combinational gated read; array and output clear on reset.
module memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] mem_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              unused_lsb;

  assign idx        = addr[IDX_W+1:2];
  // Any bit set above the word index means the address lies past the array; no wrap.
  assign in_range   = ((addr >> (IDX_W + 2)) == '0);
  assign unused_lsb = ^addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_write && in_range) begin
      mem_q[idx] <= write_data;
    end
  end

  always_comb begin
    mem_data = '0;
    if (rst && mem_read && in_range) begin
      mem_data = mem_q[idx];
    end
  end

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - self-checking bench for memory
// Vector table, hand-written corner sequences, and randomized traffic against an array model.
module tb_memory;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] mem_data;

  int checks;
  int failures;

  logic [31:0] model [DEPTH];

  memory #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .write_data(write_data),
    .mem_data  (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_after;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a);
    if (rd && a < DEPTH * 4) return model[a / 4];
    return 32'h0;
  endfunction

  task automatic model_write(input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (wr && a < DEPTH * 4) model[a / 4] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    addr       = 32'd0;
    write_data = 32'h0;
    model_clear();

    #2;
    check("reset_out_low", mem_data, 32'h0);
    step();
    rst = 1'b1;
    addr = 32'd512;
    #1;
    check("cleared_word128", mem_data, 32'h0);

    vecs[0]  = '{1'b1, 1'b0, 32'd200,        32'h00000ABC, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'd200,        32'h0,        32'h00000ABC};
    vecs[2]  = '{1'b1, 1'b0, 32'd200,        32'h00001234, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'd201,        32'h0,        32'h00001234};
    vecs[4]  = '{1'b0, 1'b1, 32'd203,        32'h0,        32'h00001234};
    vecs[5]  = '{1'b1, 1'b0, 32'd1024,       32'hDEADBEEF, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 32'd1024,       32'h0,        32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'd0,          32'h0,        32'h0};
    vecs[8]  = '{1'b1, 1'b1, 32'd1020,       32'hCAFEF00D, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 1'b1, 32'd1023,       32'h0,        32'hCAFEF00D};
    vecs[10] = '{1'b0, 1'b0, 32'd1020,       32'h0,        32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'hFFFFFFFC,   32'h00000001, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 32'hFFFFFFFC,   32'h0,        32'h0};
    vecs[13] = '{1'b0, 1'b1, 32'd1020,       32'h0,        32'hCAFEF00D};
    vecs[14] = '{1'b0, 1'b1, 32'd2044,       32'h0,        32'h0};

    for (int i = 0; i < 15; i++) begin
      mem_write  = vecs[i].wr;
      mem_read   = vecs[i].rd;
      addr       = vecs[i].a;
      write_data = vecs[i].wd;
      step();
      mem_write = 1'b0;
      #1;
      check($sformatf("vec%0d", i), mem_data, vecs[i].exp_after);
      model_write(vecs[i].wr, vecs[i].a, vecs[i].wd);
    end

    // Simultaneous read and write to the same word: old before the edge, new after.
    mem_write = 1'b1; mem_read = 1'b0; addr = 32'd8; write_data = 32'h5;
    step();
    mem_read = 1'b1; write_data = 32'h7;
    #1;
    check("rw_before_edge", mem_data, 32'h5);
    step();
    check("rw_after_edge", mem_data, 32'h7);
    mem_write = 1'b0;
    model[2] = 32'h7;

    // Reset pulse mid-cycle, with a write edge landing inside the reset window.
    mem_write = 1'b1; mem_read = 1'b1; addr = 32'd200; write_data = 32'h00000ABC;
    step();
    mem_write = 1'b0;
    #1;
    check("fill_before_rst", mem_data, 32'h00000ABC);
    rst = 1'b0;
    #1;
    check("rst_drops_out", mem_data, 32'h0);
    mem_write = 1'b1; write_data = 32'h99;
    step();
    mem_write = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_cleared_200", mem_data, 32'h0);
    addr = 32'd8;
    #1;
    check("rst_cleared_8", mem_data, 32'h0);
    model_clear();

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic        wr, rd;
      logic [31:0] d;
      case ($urandom_range(0, 9))
        0:       a = $urandom_range(1024, 4095);
        1:       a = $urandom;
        2:       a = 32'd1020 + $urandom_range(0, 3);
        default: a = $urandom_range(0, 255);
      endcase
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 3) != 0);
      d  = $urandom;
      mem_write = wr; mem_read = rd; addr = a; write_data = d;
      #1;
      check($sformatf("rnd%0d_pre a=%h", n, a), mem_data, model_read(rd, a));
      step();
      model_write(wr, a, d);
      mem_write = 1'b0;
      #1;
      check($sformatf("rnd%0d_post a=%h", n, a), mem_data, model_read(rd, a));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
